instr_encoder: RTL
==================

Name: instr_encoder

Overview:
Sequential instruction encoder and instruction-memory loader; the inverse of the CPU main decoder.
Accepts field-level instruction requests (opcode plus register, funct, immediate or target fields) over a valid/ready handshake.
Packs each request into an n-bit machine word in the CPU's 16-bit format and writes the words to consecutive instruction-memory addresses.
Sits between the bench or boot-loader front end and the instruction memory write port.

Parameters:
n, 16, instruction word width; the format is defined for 16 only.
DEPTH, 64, number of instruction-memory words (power of 2, ≤ 2^13).
AW, $clog2(DEPTH), width of the write address.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse: begin a load at address 0.
finish  in  1  one-cycle pulse: end the load early.
in_valid  in  1  request valid.
in_ready  out  1  encoder can accept a request.
in_op  in  3  opcode.
in_rs, in_rt, in_rd  in  3 each  register indices.
in_funct  in  4  R-type function code.
in_imm  in  16  signed immediate for LW, SW, ADDI and BEQ.
in_target  in  16  unsigned jump target for J and JAL.
imem_we  out  1  write strobe.
imem_addr  out  AW  write address.
imem_wdata  out  n  encoded word.
busy  out  1  load in progress.
done  out  1  load complete; held high until the next start or reset.
err_count  out  8  number of rejected requests, saturating at 255.

Behaviour:
- Word formats (op always in [15:13]):
  - RTYPE 000: rs[12:10], rt[9:7], rd[6:4], funct[3:0].
  - LW 001, SW 010, ADDI 011, BEQ 101: rs[12:10], rt[9:7], imm[6:0] (two's complement).
  - J 110, JAL 111: target[12:0].
- Opcode 100 is reserved. A request with op 100 is rejected.
- Range checks; a violating request is rejected:
  - I-type in_imm must lie in -64..63.
  - J-type in_target must be < 2^13.
  - Unused input fields are ignored and do not cause rejection.
- FSM states: IDLE, RUN, DONE.
  - IDLE to RUN on start. Clears the address counter to 0, clears done, clears err_count.
  - RUN to DONE on finish, or when the word at address DEPTH-1 is accepted.
  - DONE to RUN on start, with the same clears as IDLE to RUN.
  - start in RUN restarts at address 0 and clears err_count. A request accepted in that same cycle is discarded.
  - finish outside RUN is ignored.
  - start and finish in the same cycle: start wins.
- Handshake:
  - in_ready = (state == RUN); purely combinational from state.
  - A transfer occurs when in_valid && in_ready.
  - A request accepted in the cycle that finish is asserted is still encoded and written; finish takes effect after it.
- Write timing: one-cycle latency, registered outputs.
  - An accepted valid request at edge k drives imem_we=1, imem_addr=addr, imem_wdata=word after edge k.
  - The address counter then increments; no wrap, since DONE is entered at DEPTH-1.
- Rejected requests:
  - Consume the handshake; imem_we stays 0; address unchanged.
  - err_count increments and saturates at 255.
- Status outputs: busy = (state == RUN); done = (state == DONE).
- Reset, including mid-load: state IDLE, imem_we=0, imem_addr=0, imem_wdata=0, err_count=0, in_ready=0, busy=0, done=0. A partial load is abandoned and no further writes occur.
- Back-to-back accepted requests write on consecutive cycles at full throughput.

Decomposition:
- Shared package cpu_pkg:
  - opcode enum: OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_RSVD, OP_BEQ, OP_J, OP_JAL.
  - Field bit-position constants.
  - IMM_MIN / IMM_MAX, TARGET_W.
- The main decoder should migrate to the same opcode enum.
- One sub-module: instr_pack. Purely combinational; takes the fields and returns {word, legal}. Reusable by the bench's reference model.

Test Plan:
- Reset, start, then RTYPE with rs=1, rt=2, rd=3, funct=4 → next cycle imem_we=1, addr=0, wdata=16'h0534.
- Sequence LW (rs=0, rt=1, imm=-1), ADDI (rs=2, rt=2, imm=63), J (target=0x0ABC) on consecutive cycles → words 16'h20FF, 16'h693F, 16'hCABC at addr 0, 1, 2 on consecutive cycles.
- Reject cases: op=100; BEQ with imm=64; JAL with target=16'h2000 → no writes, err_count=3, the next legal request lands at addr 0.
- DEPTH legal requests → the last write lands at DEPTH-1, done=1, in_ready=0; further in_valid is ignored.
- finish after 5 words → done=1, no 6th write; start again → addr restarts at 0, err_count cleared.
- reset asserted mid-load after 3 writes → all outputs at reset values the next cycle; start then writes at addr 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit CPU instruction format: opcode enum,
// field bit positions, immediate/target limits and the encoder FSM states.
// Used by the instruction encoder and intended for the main decoder as well,
// so both sides agree on one opcode encoding.
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_RTYPE = 3'b000,
    OP_LW    = 3'b001,
    OP_SW    = 3'b010,
    OP_ADDI  = 3'b011,
    OP_RSVD  = 3'b100,
    OP_BEQ   = 3'b101,
    OP_J     = 3'b110,
    OP_JAL   = 3'b111
  } opcode_e;

  // Field bit positions inside the 16-bit word.
  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 13;
  localparam int RS_MSB    = 12;
  localparam int RS_LSB    = 10;
  localparam int RT_MSB    = 9;
  localparam int RT_LSB    = 7;
  localparam int RD_MSB    = 6;
  localparam int RD_LSB    = 4;
  localparam int FUNCT_MSB = 3;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 6;
  localparam int IMM_LSB   = 0;

  localparam int IMM_W    = 7;
  localparam int IMM_MIN  = -64;
  localparam int IMM_MAX  = 63;
  localparam int TARGET_W = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } enc_state_e;

  // One field-level instruction request as presented by the front end.
  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [3:0]  funct;
    logic [15:0] imm;
    logic [15:0] target;
  } instr_req_t;

  // A 16-bit two's complement value lies in IMM_MIN..IMM_MAX exactly when
  // bits [15:IMM_W-1] are all copies of the sign bit.
  function automatic logic imm_fits(input logic [15:0] imm);
    return (imm[15:IMM_W-1] == '0) || (imm[15:IMM_W-1] == '1);
  endfunction

  // Jump targets are unsigned and must fit in TARGET_W bits.
  function automatic logic target_fits(input logic [15:0] target);
    return target[15:TARGET_W] == '0;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
// Bundles the request handshake (valid/ready plus instruction fields) and the
// instruction-memory write port of the encoder.
//   master : request producer / memory observer (front end, bench)
//   slave  : the encoder (consumes requests, drives the write port)
// Parameters: N = word width, AW = write address width.
// -----------------------------------------------------------------------------
interface instr_encoder_if #(
  parameter int N  = 16,
  parameter int AW = 6
);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [2:0]    in_rs;
  logic [2:0]    in_rt;
  logic [2:0]    in_rd;
  logic [3:0]    in_funct;
  logic [15:0]   in_imm;
  logic [15:0]   in_target;

  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [N-1:0]  imem_wdata;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_target,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_target,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
// Purely combinational packer: turns one field-level request into a 16-bit
// machine word and flags whether the request is legal.
//   req   in   instruction fields (op, rs, rt, rd, funct, imm, target)
//   word  out  packed machine word (0 when the request is illegal)
//   legal out  1 when the opcode is defined and its operands are in range
// Fields not used by the opcode are ignored and never cause rejection.
// -----------------------------------------------------------------------------
module instr_pack
  import cpu_pkg::*;
(
  input  instr_req_t  req,
  output logic [15:0] word,
  output logic        legal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    word  = '0;
    legal = 1'b0;

    case (opcode_e'(req.op))
      OP_RTYPE: begin
        word[OP_MSB:OP_LSB]       = req.op;
        word[RS_MSB:RS_LSB]       = req.rs;
        word[RT_MSB:RT_LSB]       = req.rt;
        word[RD_MSB:RD_LSB]       = req.rd;
        word[FUNCT_MSB:FUNCT_LSB] = req.funct;
        legal                     = 1'b1;
      end

      OP_LW, OP_SW, OP_ADDI, OP_BEQ: begin
        legal = imm_fits(req.imm);
        if (legal) begin
          word[OP_MSB:OP_LSB]   = req.op;
          word[RS_MSB:RS_LSB]   = req.rs;
          word[RT_MSB:RT_LSB]   = req.rt;
          word[IMM_MSB:IMM_LSB] = req.imm[IMM_W-1:0];
        end
      end

      OP_J, OP_JAL: begin
        legal = target_fits(req.target);
        if (legal) begin
          word[OP_MSB:OP_LSB]     = req.op;
          word[TARGET_W-1:0]      = req.target[TARGET_W-1:0];
        end
      end

      OP_RSVD: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Sequential instruction encoder and instruction-memory loader. Accepts
// field-level requests over valid/ready while a load is running, packs each
// into a 16-bit word and writes it to consecutive instruction-memory
// addresses starting at 0, one cycle after acceptance.
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high reset
//   start      in   pulse: begin (or restart) a load at address 0
//   finish     in   pulse: end the load early (ignored outside a load)
//   bus        slave modport: request handshake + memory write port
//   busy       out  load in progress
//   done       out  load complete, held until next start or reset
//   err_count  out  rejected requests in this load, saturating at 255
// -----------------------------------------------------------------------------
module instr_encoder
  import cpu_pkg::*;
#(
  parameter int n     = 16,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 finish,
  instr_encoder_if.slave       bus,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           err_count
);

  enc_state_e    state, state_next;
  logic [AW-1:0] wr_ptr;
  instr_req_t    req;
  logic [15:0]   word;
  logic          legal;
  logic          accept;
  logic          write_last;

  assign req = '{op:     bus.in_op,
                 rs:     bus.in_rs,
                 rt:     bus.in_rt,
                 rd:     bus.in_rd,
                 funct:  bus.in_funct,
                 imm:    bus.in_imm,
                 target: bus.in_target};

  instr_pack u_pack (
    .req   (req),
    .word  (word),
    .legal (legal)
  );

  assign bus.in_ready = (state == ST_RUN);
  assign busy         = (state == ST_RUN);
  assign done         = (state == ST_DONE);

  assign accept     = bus.in_valid && bus.in_ready;
  // The word that fills the last location ends the load, so the pointer
  // never needs to wrap.
  assign write_last = accept && legal && (wr_ptr == AW'(DEPTH - 1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        // start beats finish; a request arriving with finish is still written.
        if (start)                     state_next = ST_RUN;
        else if (finish || write_last) state_next = ST_DONE;
      end
      ST_DONE: if (start) state_next = ST_RUN;
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write port, address counter, error counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      err_count      <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      if (start) begin
        // A request accepted alongside a restart is dropped.
        wr_ptr    <= '0;
        err_count <= '0;
      end else if (accept) begin
        if (legal) begin
          bus.imem_we    <= 1'b1;
          bus.imem_addr  <= wr_ptr;
          bus.imem_wdata <= n'(word);
          wr_ptr         <= wr_ptr + 1'b1;
        end else if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule
